dig2ana_reg_init: RTL and testbench
===================================

# dig2ana_reg_init

Register-bus initiator for the digital-to-analog configuration space. It accepts single read/write commands on a valid/ready command port, drives the `reg_cs`/`reg_wr`/`reg_addr`/`reg_wdata`/`reg_be` bus toward a register responder, and waits for `reg_ack`. It then returns read data and status on a valid/ready response port. It sits between a sequencer or bridge and the analog mux-select register block, with one transaction outstanding at a time.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 4, address width
- `BW`, 4, byte-enable width
- `TMO_CYC`, 16, cycles `reg_cs` may stay high without `reg_ack` before the timeout fires (used only with the timeout feature); legal values are 2..255

Ports:
- `mclk`  in  1  clock; one clock domain, everything on the rising edge
- `h_reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`
- `cmd_wr`  in  1  1 = write, 0 = read
- `cmd_addr`  in  AW  register address
- `cmd_wdata`  in  DW  write data
- `cmd_be`  in  BW  byte enables
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  DW  read data; 0 for writes and for timeouts
- `rsp_err`  out  1  transaction timed out
- `busy`  out  1  state is not IDLE
- `reg_cs`  out  1  bus chip select
- `reg_wr`  out  1  bus write strobe
- `reg_addr`  out  AW  bus address
- `reg_wdata`  out  DW  bus write data
- `reg_be`  out  BW  bus byte enables
- `reg_rdata`  in  DW  responder read data, valid when `reg_ack` = 1
- `reg_ack`  in  1  responder acknowledge

## Operation
- FSM states: IDLE, REQ, RESP.
- `cmd_ready` = (state == IDLE). It is combinational from the state register.
- IDLE → REQ on a handshake (`cmd_valid` & `cmd_ready`):
  - register `cmd_wr`/`cmd_addr`/`cmd_wdata`/`cmd_be` onto the `reg_*` outputs;
  - set `reg_cs` = 1;
  - clear the timeout counter.
- REQ, `reg_ack` sampled = 1:
  - `reg_cs` ← 0;
  - `rsp_rdata` ← `reg_wr` ? 0 : `reg_rdata`;
  - `rsp_err` ← 0, `rsp_valid` ← 1;
  - go to RESP.
  - `reg_cs` must drop on this same edge so the responder does not issue a second ack.
- REQ, no ack: the timeout counter increments (saturating, width `$clog2(TMO_CYC+1)`).
- RESP: hold `rsp_*` stable until `rsp_ready` = 1, then `rsp_valid` ← 0 and go to IDLE.
- `reg_ack` sampled outside REQ (late or spurious ack) is ignored: no state change, no data capture.
- `reg_addr`/`reg_wr`/`reg_wdata`/`reg_be` hold their last values while `reg_cs` = 0. They change only on a command handshake.
- `busy` = (state != IDLE).

## Timing
- Reset value of every output is 0, except `cmd_ready`, which is 1 once the state is IDLE (the cycle after reset).
- While `h_reset` is high, `cmd_ready` is forced to 0.
- A reset asserted mid-transaction (REQ or RESP):
  - `reg_cs` and `rsp_valid` go to 0 at the next edge;
  - the pending command is discarded;
  - no response is produced.
- Latency against a responder that acks one cycle after `cs`:
  - handshake at edge E0 → `reg_cs` high after E0;
  - responder acks after E1;
  - master samples ack at E2 → `reg_cs` low, `rsp_valid` high after E2;
  - `reg_cs` is high for exactly 2 cycles.
- Back-to-back throughput with `rsp_ready` tied high is one command every 4 cycles: accept, cs, cs, resp. The next handshake happens in the cycle after RESP exits.
- If ack and timeout expiry coincide on the same edge, the ack wins: `rsp_err` = 0 and the data is captured.

## Configuration
- Macro: `DIG2ANA_REG_INIT_TIMEOUT_EN`.
- Defined:
  - in REQ, when the counter reaches `TMO_CYC` with no ack, `reg_cs` ← 0, `rsp_valid` ← 1, `rsp_err` ← 1, `rsp_rdata` ← 0, go to RESP;
  - a later ack is ignored.
- Undefined:
  - no counter is instantiated;
  - REQ waits indefinitely for `reg_ack`;
  - `rsp_err` is tied to 0.

## Test plan
- Write: cmd wr=1, addr=2, wdata=0x0000_005A, be=0x1, against the DAC mux-select register responder → `reg_cs` high 2 cycles with `reg_wr`=1 and `reg_addr`=2; one `rsp_valid` pulse with `rsp_err`=0 and `rsp_rdata`=0; responder register 2 reads 0x5A.
- Read-back: cmd wr=0, addr=2 → `rsp_rdata`=0x0000_005A, `rsp_err`=0; a read of addr=7 → `rsp_rdata`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_valid`/`rsp_rdata` stable, `cmd_ready`=0, `busy`=1 throughout; one cycle after `rsp_ready` rises, `cmd_ready`=1.
- Timeout (macro defined, `TMO_CYC`=16, `reg_ack` tied 0) → `reg_cs` drops after 16 cycles high; `rsp_err`=1, `rsp_rdata`=0; an injected `reg_ack` pulse 3 cycles later causes no second response. With the macro undefined, `reg_cs` is still high after 1000 cycles.
- Reset mid-REQ: assert `h_reset` for 1 cycle while `reg_cs`=1 → `reg_cs`=0 and `rsp_valid`=0 after that edge; `cmd_ready`=1 the following cycle; the next command completes normally.
- Back-to-back: 4 writes to addr 0..3 with data 0x11/0x22/0x33/0x44 and `rsp_ready`=1 → 4 responses spaced 4 cycles apart; read-back of each address returns its value.

Source files
------------

// File: rtl/dig2ana_reg_init.sv
// ---------------------------------------------------------------------------
// dig2ana_reg_init
//
// Register-bus initiator for the digital-to-analog configuration space.
// Takes one read/write command at a time on a valid/ready command port,
// drives it onto the reg_* bus, waits for reg_ack and returns read data
// plus status on a valid/ready response port.
//
// Optional feature macro: DIG2ANA_REG_INIT_TIMEOUT_EN
//   defined   -> a REQ that sees no reg_ack for TMO_CYC cycles is closed
//                with rsp_err = 1 and rsp_rdata = 0
//   undefined -> REQ waits for reg_ack forever, rsp_err is always 0
//
// Ports:
//   mclk, h_reset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_wr/addr/wdata/be      command payload (wr = 1 means write)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        read data (0 for writes/timeouts), timeout flag
//   busy                      high whenever a transaction is in flight
//   reg_cs/wr/addr/wdata/be   register bus toward the responder
//   reg_rdata, reg_ack        responder read data and acknowledge
// ---------------------------------------------------------------------------
module dig2ana_reg_init #(
   parameter int DW      = 32,
   parameter int AW      = 4,
   parameter int BW      = 4,
   parameter int TMO_CYC = 16
) (
   input  logic          mclk,
   input  logic          h_reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_wr,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [BW-1:0] cmd_be,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          busy,
   output logic          reg_cs,
   output logic          reg_wr,
   output logic [AW-1:0] reg_addr,
   output logic [DW-1:0] reg_wdata,
   output logic [BW-1:0] reg_be,
   input  logic [DW-1:0] reg_rdata,
   input  logic          reg_ack
);

   // The timeout counter width assumes TMO_CYC stays in its legal range.
   if (TMO_CYC < 2 || TMO_CYC > 255) begin : g_bad_tmo_cyc
      $error("dig2ana_reg_init: TMO_CYC must be within 2..255");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            reg_cs_q, reg_cs_d;
   logic            reg_wr_q, reg_wr_d;
   logic [AW-1:0]   reg_addr_q, reg_addr_d;
   logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
   logic [BW-1:0]   reg_be_q, reg_be_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

`ifdef DIG2ANA_REG_INIT_TIMEOUT_EN
   localparam int            TMO_W    = $clog2(TMO_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_CYC);
   // The counter holds the number of ack-less REQ cycles already seen, so
   // the edge that completes the TMO_CYC-th such cycle is the one where the
   // counter still reads TMO_CYC-1.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   // Next-state and datapath logic. The reg_* payload is only reloaded on a
   // command handshake so the bus holds its last values while reg_cs is low.
   // An ack seen outside REQ falls through untouched, which is how late or
   // spurious acks are ignored.
   always_comb begin
      state_d     = state_q;
      reg_cs_d    = reg_cs_q;
      reg_wr_d    = reg_wr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_be_d    = reg_be_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef DIG2ANA_REG_INIT_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d     = REQ;
               reg_cs_d    = 1'b1;
               reg_wr_d    = cmd_wr;
               reg_addr_d  = cmd_addr;
               reg_wdata_d = cmd_wdata;
               reg_be_d    = cmd_be;
`ifdef DIG2ANA_REG_INIT_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
            end
         end

         REQ: begin
            // Ack is checked first so it wins over a coinciding timeout;
            // reg_cs drops on this same edge to avoid a second ack.
            if (reg_ack) begin
               state_d     = RESP;
               reg_cs_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = reg_wr_q ? '0 : reg_rdata;
            end
`ifdef DIG2ANA_REG_INIT_TIMEOUT_EN
            else if (tmo_cnt_q >= TMO_LAST) begin
               state_d     = RESP;
               reg_cs_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else if (tmo_cnt_q != TMO_MAX) begin
               tmo_cnt_d   = tmo_cnt_q + 1'b1;
            end
`endif
         end

         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset discards any pending command outright: the bus
   // and the response port both return to idle with no response produced.
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         state_q     <= IDLE;
         reg_cs_q    <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_be_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         reg_cs_q    <= reg_cs_d;
         reg_wr_q    <= reg_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_be_q    <= reg_be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef DIG2ANA_REG_INIT_TIMEOUT_EN
   // Timeout counter register, cleared on every accepted command.
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

   // cmd_ready is masked by reset so nothing is accepted while it is held.
   assign cmd_ready = (state_q == IDLE) && !h_reset;
   assign busy      = (state_q != IDLE);
   assign reg_cs    = reg_cs_q;
   assign reg_wr    = reg_wr_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_be    = reg_be_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
`ifdef DIG2ANA_REG_INIT_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dig2ana_reg_init.sv
// ---------------------------------------------------------------------------
// tb_dig2ana_reg_init
//
// Directed bench for dig2ana_reg_init. A small behavioural register
// responder (16 x 32-bit, byte-enabled writes, acks one cycle after cs)
// sits on the reg_* bus. Honours DIG2ANA_REG_INIT_TIMEOUT_EN the same way
// the design does.
// ---------------------------------------------------------------------------
module tb_dig2ana_reg_init;

   localparam int DW      = 32;
   localparam int AW      = 4;
   localparam int BW      = 4;
   localparam int TMO_CYC = 16;

   logic          mclk = 1'b0;
   logic          h_reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [BW-1:0] cmd_be;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          busy;
   logic          reg_cs;
   logic          reg_wr;
   logic [AW-1:0] reg_addr;
   logic [DW-1:0] reg_wdata;
   logic [BW-1:0] reg_be;
   logic [DW-1:0] reg_rdata;
   logic          reg_ack;

   logic          ack_en;
   logic          inj_ack;
   logic [DW-1:0] mem [16];

   int checks = 0;
   int fails  = 0;

   dig2ana_reg_init #(
      .DW(DW), .AW(AW), .BW(BW), .TMO_CYC(TMO_CYC)
   ) dut (
      .mclk(mclk), .h_reset(h_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_be(reg_be),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack)
   );

   always #5 mclk = ~mclk;

   // Behavioural responder: acks the cycle after it sees cs (once per
   // access), performs the write or presents read data alongside the ack.
   // inj_ack forces a stray ack pulse regardless of cs.
   always @(posedge mclk) begin
      if (h_reset) begin
         reg_ack   <= 1'b0;
         reg_rdata <= '0;
      end else begin
         reg_ack <= inj_ack;
         if (reg_cs && !reg_ack && ack_en) begin
            reg_ack <= 1'b1;
            if (reg_wr) begin
               for (int b = 0; b < BW; b++) begin
                  if (reg_be[b]) mem[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
               end
            end else begin
               reg_rdata <= mem[reg_addr];
            end
         end
      end
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one command (called on a falling edge) and follows it until
   // rsp_valid is seen or the cycle budget expires. Returns on the falling
   // edge where rsp_valid is first high, without consuming it.
   task automatic applyStimulus(
      input  logic          wr,
      input  logic [AW-1:0] addr,
      input  logic [DW-1:0] wdata,
      input  logic [BW-1:0] be,
      input  int            budget,
      output logic [DW-1:0] rdata,
      output logic          err,
      output int            cs_cycles,
      output logic          seen_wr,
      output logic [AW-1:0] seen_addr,
      output logic          done
   );
      int n;
      done = 1'b0; rdata = '0; err = 1'b0; cs_cycles = 0;
      seen_wr = 1'b0; seen_addr = '0;
      n = 0;
      while (!cmd_ready && n < budget) begin
         @(negedge mclk);
         n++;
      end
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
      @(negedge mclk);
      cmd_valid = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (rsp_valid) begin
            done  = 1'b1;
            rdata = rsp_rdata;
            err   = rsp_err;
            break;
         end
         if (reg_cs) begin
            if (cs_cycles == 0) begin
               seen_wr   = reg_wr;
               seen_addr = reg_addr;
            end
            cs_cycles++;
         end
         @(negedge mclk);
      end
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [DW-1:0] rd;
      logic          er;
      int            csn;
      logic          swr;
      logic [AW-1:0] sad;
      logic          dn;
      logic [DW-1:0] b2b_data [4];
      int            rsp_cyc [4];
      int            nrsp;
      int            sent;
      logic          stray;

      // wr, addr, wdata, be, expected rsp_rdata
      vecs[0] = '{1'b1, 4'd2, 32'h0000_005A, 4'h1, 32'h0};
      vecs[1] = '{1'b0, 4'd2, 32'h0,         4'hF, 32'h0000_005A};
      vecs[2] = '{1'b0, 4'd7, 32'h0,         4'hF, 32'h0};
      vecs[3] = '{1'b1, 4'd5, 32'hA5A5_1234, 4'hF, 32'h0};
      vecs[4] = '{1'b1, 4'd5, 32'hFFFF_FFFF, 4'h2, 32'h0};
      vecs[5] = '{1'b0, 4'd5, 32'h0,         4'hF, 32'hA5A5_FF34};

      b2b_data[0] = 32'h11; b2b_data[1] = 32'h22;
      b2b_data[2] = 32'h33; b2b_data[3] = 32'h44;

      for (int i = 0; i < 16; i++) mem[i] = '0;
      h_reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_be = '0; rsp_ready = 1'b1; ack_en = 1'b1; inj_ack = 1'b0;

      // Reset state
      repeat (3) @(negedge mclk);
      checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("reset_reg_cs",    32'(reg_cs),    32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_busy",      32'(busy),      32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata,      32'd0);
      h_reset = 1'b0;
      @(negedge mclk);
      checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

      // Table-driven single transactions
      $display("[TB] directed vectors");
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, 20,
                       rd, er, csn, swr, sad, dn);
         checkOutput($sformatf("vec%0d_done", v),     32'(dn),  32'd1);
         checkOutput($sformatf("vec%0d_cs_cycles", v), 32'(csn), 32'd2);
         checkOutput($sformatf("vec%0d_reg_wr", v),   32'(swr), 32'(vecs[v].wr));
         checkOutput($sformatf("vec%0d_reg_addr", v), 32'(sad), 32'(vecs[v].addr));
         checkOutput($sformatf("vec%0d_rdata", v),    rd,       vecs[v].exp_rdata);
         checkOutput($sformatf("vec%0d_err", v),      32'(er),  32'd0);
         @(negedge mclk);
         checkOutput($sformatf("vec%0d_rsp_pulse", v), 32'(rsp_valid), 32'd0);
         checkOutput($sformatf("vec%0d_addr_hold", v), 32'(reg_addr), 32'(vecs[v].addr));
      end

      // Backpressure on the response port
      $display("[TB] backpressure");
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 4'd2, 32'h0, 4'hF, 20, rd, er, csn, swr, sad, dn);
      checkOutput("bp_done",  32'(dn), 32'd1);
      checkOutput("bp_rdata", rd,      32'h0000_005A);
      for (int k = 0; k < 5; k++) begin
         @(negedge mclk);
         checkOutput($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
         checkOutput($sformatf("bp%0d_rsp_rdata", k), rsp_rdata,      32'h0000_005A);
         checkOutput($sformatf("bp%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
         checkOutput($sformatf("bp%0d_busy", k),      32'(busy),      32'd1);
      end
      rsp_ready = 1'b1;
      @(negedge mclk);
      checkOutput("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);

      // Back-to-back writes, one command every 4 cycles
      $display("[TB] back-to-back");
      nrsp = 0; sent = 0;
      for (int i = 0; i < 60 && nrsp < 4; i++) begin
         if (rsp_valid) begin
            rsp_cyc[nrsp] = i;
            nrsp++;
         end
         if (cmd_ready && sent < 4) begin
            cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = AW'(sent);
            cmd_wdata = b2b_data[sent]; cmd_be = 4'hF;
            sent++;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge mclk);
      end
      cmd_valid = 1'b0;
      checkOutput("b2b_rsp_count", 32'(nrsp), 32'd4);
      if (nrsp == 4) begin
         for (int i = 1; i < 4; i++)
            checkOutput($sformatf("b2b_spacing%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd4);
      end
      for (int a = 0; a < 4; a++) begin
         applyStimulus(1'b0, AW'(a), 32'h0, 4'hF, 20, rd, er, csn, swr, sad, dn);
         checkOutput($sformatf("b2b_readback%0d", a), rd, b2b_data[a]);
         @(negedge mclk);
      end

      // Reset while a request is outstanding
      $display("[TB] reset mid-request");
      ack_en = 1'b0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd9; cmd_wdata = 32'h77; cmd_be = 4'hF;
      @(negedge mclk);
      cmd_valid = 1'b0;
      checkOutput("rst_req_cs_before", 32'(reg_cs), 32'd1);
      h_reset = 1'b1;
      @(negedge mclk);
      checkOutput("rst_req_cs",        32'(reg_cs),    32'd0);
      checkOutput("rst_req_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_req_busy",      32'(busy),      32'd0);
      checkOutput("rst_req_cmd_ready_held", 32'(cmd_ready), 32'd0);
      h_reset = 1'b0;
      ack_en  = 1'b1;
      @(negedge mclk);
      checkOutput("rst_req_cmd_ready", 32'(cmd_ready), 32'd1);
      applyStimulus(1'b0, 4'd9, 32'h0, 4'hF, 20, rd, er, csn, swr, sad, dn);
      checkOutput("rst_next_done",  32'(dn),  32'd1);
      checkOutput("rst_next_cs",    32'(csn), 32'd2);
      checkOutput("rst_next_rdata", rd,       32'h0);
      @(negedge mclk);

`ifdef DIG2ANA_REG_INIT_TIMEOUT_EN
      // Timeout with a silent responder, then a stray late ack
      $display("[TB] timeout");
      ack_en = 1'b0;
      applyStimulus(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 40, rd, er, csn, swr, sad, dn);
      checkOutput("tmo_done",      32'(dn),  32'd1);
      checkOutput("tmo_cs_cycles", 32'(csn), 32'(TMO_CYC));
      checkOutput("tmo_err",       32'(er),  32'd1);
      checkOutput("tmo_rdata",     rd,       32'h0);
      repeat (2) @(negedge mclk);
      inj_ack = 1'b1;
      @(negedge mclk);
      inj_ack = 1'b0;
      stray = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (rsp_valid || busy) stray = 1'b1;
         @(negedge mclk);
      end
      checkOutput("tmo_stray_ack_ignored", 32'(stray), 32'd0);
      ack_en = 1'b1;
      applyStimulus(1'b0, 4'd3, 32'h0, 4'hF, 20, rd, er, csn, swr, sad, dn);
      checkOutput("tmo_after_rdata", rd,      32'h0000_0044);
      checkOutput("tmo_after_err",   32'(er), 32'd0);
      @(negedge mclk);
`else
      // Without the timeout feature a silent responder stalls REQ forever
      $display("[TB] no-timeout stall");
      ack_en = 1'b0;
      applyStimulus(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1000, rd, er, csn, swr, sad, dn);
      checkOutput("stall_no_rsp",    32'(dn),        32'd0);
      checkOutput("stall_cs_cycles", 32'(csn),       32'd1000);
      checkOutput("stall_cs_high",   32'(reg_cs),    32'd1);
      checkOutput("stall_busy",      32'(busy),      32'd1);
      h_reset = 1'b1;
      @(negedge mclk);
      h_reset = 1'b0;
      ack_en  = 1'b1;
      @(negedge mclk);
      checkOutput("stall_recover_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
